moonbase_mem_master: RTL
========================

// Module: moonbase_mem_master
// PURPOSE
//  CPU-side initiator for the nibble-serial external SRAM port (7-bit address, 8-bit data).
//  Accepts byte read/write requests from the core, buffers them, and sequences the pin
//  protocol: address phase, low nibble, high nibble. Returns read data / write acks.
//  Sits between the core's load/store unit and the io_out[7:0] / io_in[5:2] pads.
// PARAMETERS
//  ADDR_W     7   external address width; pin field io_out[6:0]
//  FIFO_DEPTH 2   request buffer entries; power of two, >=2
// PORTS
//  clk        in   1  clock; all pin and core-side timing is relative to its rising edge
//  rst_n      in   1  reset, asynchronous assert, active-low
//  req_valid  in   1  core request present
//  req_ready  out  1  request buffer not full; push on req_valid & req_ready
//  req_we     in   1  1 = write, 0 = read
//  req_addr   in   7  byte address
//  req_wdata  in   8  write data; ignored for reads
//  rsp_valid  out  1  one-cycle pulse per completed access, reads and writes alike
//  rsp_we     out  1  echo of req_we for the completing access
//  rsp_rdata  out  8  read byte; 8'h00 for writes; valid only while rsp_valid
//  mem_out    out  8  pad outputs (io_out)
//  mem_in     in   4  pad nibble input (io_in[5:2])
// BEHAVIOUR
//  Pin encoding:
//   - mem_out[7]=1: address phase; mem_out[6:0]=address. The responder latches the address
//     and clears its nibble-select.
//   - mem_out[7]=0: data phase; mem_out[5]=write-enable_n, mem_out[4]=data strobe_n,
//     mem_out[3:0]=write nibble, mem_out[6]=0.
//  Idle pins = 8'h30: phase 0, we_n=1, stb_n=1, nibble 0. Any state not driving a write uses
//  we_n=stb_n=1.
//  Responder nibble-select toggles every non-address cycle. Order is fixed: low nibble first,
//  then high. No wait states exist; LO and HI are exactly one cycle each.
//  FSM (registered outputs):
//   - IDLE -> ADDR when FIFO non-empty, popping the head into the active-access registers.
//   - ADDR -> LO: drive {1,addr}.
//   - LO -> HI: write drives {4'b0000, wdata[3:0]}; read drives 8'h30 and samples mem_in
//     into rdata[3:0] at the closing edge.
//   - HI -> ADDR if FIFO non-empty (pop), else IDLE: write drives {4'b0000, wdata[7:4]}
//     (responder commits at the closing edge); read samples mem_in into rdata[7:4].
//  Timing and throughput:
//   - Latency: push at edge N -> ADDR in cycle N+1, LO N+2, HI N+3, rsp_valid N+4.
//   - Back-to-back accesses occur every 3 cycles with no idle gap; rsp_valid of access k
//     coincides with ADDR of access k+1.
//  FIFO rules:
//   - req_ready = !full.
//   - Push when full is ignored; no data loss because ready is low.
//   - Push and pop in the same cycle are allowed at any occupancy except push-when-full.
//   - No bypass: an empty FIFO still costs the N+1 ADDR cycle.
//   - Pointers wrap modulo FIFO_DEPTH; a separate count disambiguates full and empty.
//  Reset (async, rst_n low):
//   - mem_out=8'h30, rsp_valid=0, rsp_we=0, rsp_rdata=0, FIFO empty, state IDLE.
//   - Reset during ADDR/LO aborts with no commit.
//   - Reset during HI of a write removes pins before the closing edge, so no commit.
//   - Reset on release takes effect immediately; the first possible ADDR is the cycle after
//     the first push.
//  Reads never drive we_n/stb_n low, so they can never corrupt memory.
// STRUCTURE
//  Package moonbase_mem_pkg:
//   - state enum {IDLE, ADDR, LO, HI}
//   - pin indices PIN_PHASE=7, PIN_WE_N=5, PIN_STB_N=4
//   - constant MEM_IDLE=8'h30
//   - request struct {we, addr, wdata}
//  Sub-module moonbase_req_fifo: parameterised sync FIFO carrying the request struct.
//  The FSM and the datapath sit in this module.
// TESTING
//  Bench attaches a behavioural responder: 128x8 array, address latch, toggling select,
//  low-nibble temp register.
//  1. Reset: rst_n=0 -> mem_out=8'h30, req_ready=1, rsp_valid=0; hold 5 clocks -> unchanged.
//  2. Write 0x5A@0x12 -> mem_out 0x92, 0x0A, 0x05, 0x30; model[0x12]=0x5A;
//     rsp_valid exactly at N+4 with rsp_we=1.
//  3. Read @0x12 after (2) -> mem_out 0x92, 0x30, 0x30; rsp_rdata=0x5A at N+4, rsp_we=0.
//  4. Push 4 requests on consecutive cycles (DEPTH=2) -> req_ready drops, ADDR cycles spaced
//     exactly 3 apart, 4 rsp pulses in order, model contents correct.
//  5. Assert rst_n=0 mid-cycle during HI of write 0xFF@0x7F -> mem_out=8'h30 immediately,
//     model[0x7F] unchanged, FIFO empty.
//  6. Random 1000 mixed reads/writes over all 128 addresses with random req_valid gaps ->
//     every read matches a shadow model; no write strobe ever seen during a read.

Source files
------------

// File: rtl/moonbase_mem_pkg.sv
// Shared types and pin-level constants for the nibble-serial SRAM initiator.
package moonbase_mem_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int PIN_PHASE = 7;
    localparam int PIN_WE_N  = 5;
    localparam int PIN_STB_N = 4;

    localparam logic [7:0] MEM_IDLE = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LO,
        HI
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [7:0] addr_pins(input logic [ADDR_W-1:0] addr);
        logic [7:0] pins;
        pins                 = '0;
        pins[PIN_PHASE]      = 1'b1;
        pins[ADDR_W-1:0]     = addr;
        return pins;
    endfunction

    // Reads keep we_n/stb_n high so a read phase can never disturb memory contents.
    function automatic logic [7:0] data_pins(input logic we, input logic [3:0] nib);
        logic [7:0] pins;
        pins = MEM_IDLE;
        if (we) begin
            pins[PIN_WE_N]  = 1'b0;
            pins[PIN_STB_N] = 1'b0;
            pins[3:0]       = nib;
        end
        return pins;
    endfunction

endpackage

// File: rtl/moonbase_req_fifo.sv
// Small synchronous request buffer; count register separates full from empty.
module moonbase_req_fifo
    import moonbase_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  mem_req_t push_data,
    input  logic     pop,
    output mem_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mem_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/moonbase_mem_master.sv
// Core-side initiator for the nibble-serial SRAM port: buffers byte requests and
// sequences address, low-nibble and high-nibble phases with registered pad outputs.
//
//  state | meaning
//  IDLE  | pads idle (8'h30), waiting for a buffered request
//  ADDR  | pads carry {1, addr}; responder latches address
//  LO    | low nibble phase (write data or read sample)
//  HI    | high nibble phase; write commits / read completes at its closing edge
module moonbase_mem_master
    import moonbase_mem_pkg::*;
#(
    parameter int ADDR_W     = moonbase_mem_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [7:0]        rsp_rdata,
    output logic [7:0]        mem_out,
    input  logic [3:0]        mem_in
);

    state_e     state_q, state_d;
    mem_req_t   act_q, act_d;
    logic [3:0] rdlo_q, rdlo_d;
    logic [7:0] mem_out_q, mem_out_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_we_q, rsp_we_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;

    mem_req_t   req_in;
    mem_req_t   fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata};

    moonbase_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data (req_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign mem_out   = mem_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        rdlo_d      = rdlo_q;
        mem_out_d   = mem_out_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = 8'h00;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                mem_out_d = MEM_IDLE;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    act_d     = fifo_head;
                    state_d   = ADDR;
                    mem_out_d = addr_pins(fifo_head.addr);
                end
            end
            ADDR: begin
                state_d   = LO;
                mem_out_d = data_pins(act_q.we, act_q.wdata[3:0]);
            end
            LO: begin
                state_d   = HI;
                rdlo_d    = mem_in;
                mem_out_d = data_pins(act_q.we, act_q.wdata[7:4]);
            end
            HI: begin
                rsp_valid_d = 1'b1;
                rsp_we_d    = act_q.we;
                rsp_rdata_d = act_q.we ? 8'h00 : {mem_in, rdlo_q};
                // Chain straight into the next address phase to avoid an idle gap.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    act_d     = fifo_head;
                    state_d   = ADDR;
                    mem_out_d = addr_pins(fifo_head.addr);
                end else begin
                    state_d   = IDLE;
                    mem_out_d = MEM_IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_out_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_q       <= '0;
            rdlo_q      <= '0;
            mem_out_q   <= MEM_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            rdlo_q      <= rdlo_d;
            mem_out_q   <= mem_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
